// File: rtl/softmax_pkg.sv
// Shared defaults, FSM state encoding and Q-format constants for the softmax
// normalise stage.
package softmax_pkg;

  localparam int unsigned default_data_size      = 32;
  localparam int unsigned default_number_of_data = 10;
  localparam int unsigned default_frac_bits      = 16;

  typedef enum logic [1:0] {
    COLLECT,
    DIVIDE,
    EMIT,
    FINISH
  } state_t;

  // 1.0 and the saturation word at the default Q16.16 format
  localparam logic [default_data_size-1:0] q_one =
    default_data_size'(1) << default_frac_bits;
  localparam logic [default_data_size-1:0] q_sat = '1;

endpackage

// File: rtl/softmax_normalize_block_divider.sv
// Iterative restoring divider: one quotient bit per cycle, the first step is
// taken on the start edge so done arrives dividend_width cycles after start.
module restoring_divider #(
  parameter int unsigned dividend_width = 64,
  parameter int unsigned divisor_width  = 32
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      start,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [dividend_width-1:0] quotient
);

  localparam int unsigned cnt_width = $clog2(dividend_width + 1);

  logic [divisor_width-1:0]  rem;
  logic [divisor_width-1:0]  div_reg;
  logic [cnt_width-1:0]      cnt;

  logic [divisor_width-1:0]  cur_rem;
  logic [dividend_width-1:0] cur_quo;
  logic [divisor_width-1:0]  cur_div;
  logic [divisor_width:0]    shifted;
  logic [divisor_width-1:0]  trial;
  logic                      fits;
  logic [divisor_width-1:0]  step_rem;
  logic [dividend_width-1:0] step_quo;

  // One restoring step; on start it operates on the fresh operands
  always_comb begin
    cur_rem  = start ? '0 : rem;
    cur_quo  = start ? dividend : quotient;
    cur_div  = start ? divisor : div_reg;
    shifted  = {cur_rem, cur_quo[dividend_width-1]};
    fits     = (shifted >= {1'b0, cur_div});
    trial    = shifted[divisor_width-1:0] - cur_div;
    step_rem = fits ? trial : shifted[divisor_width-1:0];
    step_quo = {cur_quo[dividend_width-2:0], fits};
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rem      <= '0;
      div_reg  <= '0;
      cnt      <= '0;
      quotient <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= step_rem;
        quotient <= step_quo;
        div_reg  <= divisor;
        cnt      <= cnt_width'(1);
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= step_rem;
        quotient <= step_quo;
        cnt      <= cnt + cnt_width'(1);
        if (cnt == cnt_width'(dividend_width - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/softmax_normalize_block.sv
// Softmax output stage: buffers the exp stream, waits for the exp-sum, then
// emits exp_k / sum for every buffered element in arrival order.
module softmax_normalize_block
  import softmax_pkg::*;
#(
  parameter int unsigned data_size      = default_data_size,
  parameter int unsigned number_of_data = default_number_of_data,
  parameter int unsigned frac_bits      = default_frac_bits
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [data_size-1:0] exp_i,
  input  logic                 exp_valid_i,
  input  logic                 exp_done_i,
  input  logic [data_size-1:0] sum_i,
  input  logic                 sum_valid_i,
  output logic [data_size-1:0] softmax_o,
  output logic                 softmax_valid_o,
  output logic                 softmax_done_o,
  output logic                 busy_o,
  output logic                 overflow_o
);

  localparam int unsigned cnt_width = $clog2(number_of_data + 1);
  localparam int unsigned quo_width = 2 * data_size;

  state_t               state;
  logic [data_size-1:0] buffer [number_of_data];
  logic [cnt_width-1:0] count;
  logic [cnt_width-1:0] rd_ptr;
  logic [data_size-1:0] sum_reg;
  logic                 sum_seen;
  logic                 done_seen;

  logic                 accept_c;
  logic [cnt_width-1:0] count_c;
  logic                 sum_seen_c;
  logic                 done_seen_c;
  logic                 last_c;
  logic                 sum_zero_c;
  logic                 sat_c;
  logic                 div_start_c;
  logic [quo_width-1:0] dividend_c;
  logic                 div_busy;
  logic                 div_done;
  logic [quo_width-1:0] quotient;

  // Flags include this cycle's updates so the hand-off to DIVIDE is immediate
  always_comb begin
    accept_c    = exp_valid_i && (count < cnt_width'(number_of_data));
    count_c     = accept_c ? count + cnt_width'(1) : count;
    sum_seen_c  = sum_seen | sum_valid_i;
    done_seen_c = done_seen | exp_done_i;
    last_c      = (rd_ptr == count - cnt_width'(1));
    sum_zero_c  = (sum_reg == '0);
    sat_c       = |quotient[quo_width-1:data_size];
    dividend_c  = quo_width'(buffer[rd_ptr]) << frac_bits;
    div_start_c = (state == DIVIDE) && !sum_zero_c && !div_busy && !div_done;
  end

  restoring_divider #(
    .dividend_width(quo_width),
    .divisor_width (data_size)
  ) u_divider (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start   (div_start_c),
    .dividend(dividend_c),
    .divisor (sum_reg),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(quotient)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state           <= COLLECT;
      count           <= '0;
      rd_ptr          <= '0;
      sum_reg         <= '0;
      sum_seen        <= 1'b0;
      done_seen       <= 1'b0;
      softmax_o       <= '0;
      softmax_valid_o <= 1'b0;
      softmax_done_o  <= 1'b0;
      busy_o          <= 1'b0;
      overflow_o      <= 1'b0;
    end else begin
      softmax_valid_o <= 1'b0;
      softmax_done_o  <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept_c) begin
            buffer[count] <= exp_i;
            busy_o        <= 1'b1;
          end
          if (exp_valid_i && !accept_c) overflow_o <= 1'b1;
          if (sum_valid_i) sum_reg <= sum_i;
          count     <= count_c;
          sum_seen  <= sum_seen_c;
          done_seen <= done_seen_c;
          if (sum_seen_c && done_seen_c) begin
            rd_ptr <= '0;
            if (count_c == '0) begin
              // Empty vector: lone done pulse, no data
              softmax_done_o <= 1'b1;
              busy_o         <= 1'b0;
              state          <= FINISH;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          if (sum_zero_c || div_done) begin
            softmax_o       <= (sum_zero_c || sat_c) ? '1 : quotient[data_size-1:0];
            softmax_valid_o <= 1'b1;
            softmax_done_o  <= last_c;
            state           <= EMIT;
          end
        end
        EMIT: begin
          rd_ptr <= rd_ptr + cnt_width'(1);
          if (last_c) begin
            busy_o <= 1'b0;
            state  <= FINISH;
          end else begin
            state <= DIVIDE;
          end
        end
        FINISH: begin
          count     <= '0;
          rd_ptr    <= '0;
          sum_reg   <= '0;
          sum_seen  <= 1'b0;
          done_seen <= 1'b0;
          state     <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_normalize_block.sv
// Randomised self-checking bench for softmax_normalize_block against a plain
// arithmetic reference (exp * 2^16 / sum, saturated, all-ones on zero sum).
module tb_softmax_normalize_block;
  import softmax_pkg::*;

  localparam int unsigned dw      = 32;
  localparam int unsigned depth   = 10;
  localparam int          div_lat = 2 * dw + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [dw-1:0] exp_in;
  logic          exp_valid;
  logic          exp_done;
  logic [dw-1:0] sum_in;
  logic          sum_valid;
  logic [dw-1:0] softmax;
  logic          softmax_valid;
  logic          softmax_done;
  logic          busy;
  logic          overflow;

  softmax_normalize_block dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .exp_i          (exp_in),
    .exp_valid_i    (exp_valid),
    .exp_done_i     (exp_done),
    .sum_i          (sum_in),
    .sum_valid_i    (sum_valid),
    .softmax_o      (softmax),
    .softmax_valid_o(softmax_valid),
    .softmax_done_o (softmax_done),
    .busy_o         (busy),
    .overflow_o     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [dw-1:0] mon_val[$];
  bit            mon_valid[$];
  bit            mon_done[$];
  int            mon_cyc[$];

  always @(negedge clk) begin
    if (softmax_valid || softmax_done) begin
      mon_val.push_back(softmax);
      mon_valid.push_back(softmax_valid);
      mon_done.push_back(softmax_done);
      mon_cyc.push_back(cyc);
    end
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  bit            ovf_model = 1'b0;
  logic [dw-1:0] stim[$];
  int            sum_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [dw-1:0] ref_div(input logic [dw-1:0] e, input logic [dw-1:0] s);
    longint unsigned num;
    longint unsigned q;
    if (s == '0) return q_sat;
    num = longint'(e) * 65536;
    q   = num / longint'(s);
    if (q > 64'h0000_0000_FFFF_FFFF) return q_sat;
    return q[dw-1:0];
  endfunction

  task automatic idle_inputs();
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    sum_valid = 1'b0;
    exp_in    = '0;
    sum_in    = '0;
  endtask

  task automatic clear_monitor();
    mon_val.delete();
    mon_valid.delete();
    mon_done.delete();
    mon_cyc.delete();
  endtask

  // Sends stim[], exp_done with the last exp, sum sum_gap cycles later
  task automatic drive_vector(input logic [dw-1:0] sum, input int sum_gap, input bit junk);
    int last;
    last = stim.size() - 1;
    clear_monitor();
    if (stim.size() > depth) ovf_model = 1'b1;
    if (stim.size() == 0) begin
      @(negedge clk);
      idle_inputs();
      exp_done = 1'b1;
      if (sum_gap == 0) begin
        sum_valid = 1'b1;
        sum_in    = sum;
        sum_cyc   = cyc;
      end
    end else begin
      for (int i = 0; i <= last; i++) begin
        @(negedge clk);
        idle_inputs();
        exp_in    = stim[i];
        exp_valid = 1'b1;
        exp_done  = (i == last);
        if (i == last && sum_gap == 0) begin
          sum_valid = 1'b1;
          sum_in    = sum;
          sum_cyc   = cyc;
        end
      end
    end
    for (int g = 1; g <= sum_gap; g++) begin
      @(negedge clk);
      idle_inputs();
      if (g == sum_gap) begin
        sum_valid = 1'b1;
        sum_in    = sum;
        sum_cyc   = cyc;
      end
    end
    @(negedge clk);
    idle_inputs();
    if (junk) begin
      // Arrives after the vector is closed and must be ignored
      exp_in    = $urandom;
      exp_valid = 1'b1;
      exp_done  = 1'b1;
      sum_in    = $urandom;
      sum_valid = 1'b1;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic finish_vector(input logic [dw-1:0] sum, input string tag);
    int budget;
    bit seen;
    int n;
    int want_n;
    int gap;
    budget = 3000;
    seen   = 1'b0;
    while (!seen && budget > 0) begin
      @(negedge clk);
      budget--;
      foreach (mon_done[i]) if (mon_done[i]) seen = 1'b1;
    end
    check_eq({tag, "_finished"}, 64'(seen), 64'(1));
    repeat (4) @(negedge clk);
    n      = (stim.size() > depth) ? depth : stim.size();
    want_n = (n == 0) ? 1 : n;
    gap    = (sum == '0) ? 2 : div_lat;
    check_eq({tag, "_nout"}, 64'(mon_val.size()), 64'(want_n));
    if (mon_val.size() == want_n) begin
      if (n == 0) begin
        check_eq({tag, "_empty_valid"}, 64'(mon_valid[0]), 64'(0));
        check_eq({tag, "_empty_done"}, 64'(mon_done[0]), 64'(1));
        check_eq({tag, "_empty_lat"}, 64'(mon_cyc[0] - sum_cyc), 64'(1));
      end else begin
        for (int i = 0; i < n; i++) begin
          check_eq($sformatf("%s_val%0d", tag, i), 64'(mon_val[i]), 64'(ref_div(stim[i], sum)));
          check_eq($sformatf("%s_vld%0d", tag, i), 64'(mon_valid[i]), 64'(1));
          check_eq($sformatf("%s_done%0d", tag, i), 64'(mon_done[i]), 64'(i == n - 1));
          if (i == 0)
            check_eq({tag, "_lat"}, 64'(mon_cyc[0] - sum_cyc), 64'(gap));
          else
            check_eq($sformatf("%s_gap%0d", tag, i), 64'(mon_cyc[i] - mon_cyc[i-1]), 64'(gap));
        end
      end
    end
    check_eq({tag, "_busy_idle"}, 64'(busy), 64'(0));
    check_eq({tag, "_overflow"}, 64'(overflow), 64'(ovf_model));
  endtask

  task automatic run_vector(input logic [dw-1:0] sum, input int sum_gap, input bit junk,
                            input string tag);
    drive_vector(sum, sum_gap, junk);
    finish_vector(sum, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_o"}, 64'(softmax), 64'(0));
    check_eq({tag, "_valid"}, 64'(softmax_valid), 64'(0));
    check_eq({tag, "_done"}, 64'(softmax_done), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy), 64'(0));
    check_eq({tag, "_ovf"}, 64'(overflow), 64'(0));
  endtask

  initial begin
    logic [dw-1:0] s;
    int            n;
    int            mode;

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    stim = '{q_one, q_one};
    run_vector(32'h0002_0000, 0, 1'b0, "t1");

    stim = '{q_one, 32'h0000_8000, 32'h0000_8000};
    drive_vector(32'h0002_0000, 5, 1'b0);
    check_eq("t2_busy_mid", 64'(busy), 64'(1));
    finish_vector(32'h0002_0000, "t2");

    stim = '{32'h0000_1000, 32'h0000_1000};
    run_vector(32'h0, 0, 1'b0, "t3_zero");

    stim = '{32'h0002_0000};
    run_vector(q_one, 0, 1'b0, "t5_two");

    stim = '{32'hFFFF_0000};
    run_vector(32'h0000_0001, 1, 1'b0, "t5_sat");

    stim = '{};
    run_vector(32'h0001_2345, 2, 1'b0, "empty");

    for (int r = 0; r < 8; r++) begin
      n    = $urandom_range(0, depth);
      mode = $urandom_range(0, 3);
      stim = '{};
      s    = '0;
      for (int i = 0; i < n; i++) begin
        stim.push_back($urandom & 32'h00FF_FFFF);
        s = s + stim[i];
      end
      case (mode)
        0:       s = '0;
        1:       s = s;
        2:       s = $urandom;
        default: s = $urandom_range(1, 255);
      endcase
      run_vector(s, $urandom_range(0, 4), 1'b1, $sformatf("rnd%0d", r));
    end

    stim = '{};
    for (int i = 0; i < depth + 1; i++) stim.push_back(32'(i + 1) << 16);
    run_vector(32'h000A_0000, 0, 1'b0, "t4_ovf");
    repeat (5) @(negedge clk);
    check_eq("t4_ovf_sticky", 64'(overflow), 64'(1));

    stim = '{q_one, q_one};
    drive_vector(32'h0002_0000, 0, 1'b0);
    while (cyc < sum_cyc + 20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ovf_model = 1'b0;
    check_reset_outputs("t6_reset");
    clear_monitor();
    repeat (150) @(negedge clk);
    check_eq("t6_no_output", 64'(mon_val.size()), 64'(0));

    stim = '{q_one, q_one};
    run_vector(32'h0002_0000, 0, 1'b0, "t6_clean");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_normalize_block.md
Name: softmax_normalize_block

Overview:
- Final softmax stage: consumes the exp stream and the exp-sum, and emits each normalised probability exp_k / sum in arrival order.
- Buffers up to number_of_data exp values while the sum accumulates.
- Once the sum is valid, divides each buffered value with an iterative restoring divider.
- Drives the softmax output stream and a done pulse. Sits directly downstream of the exp and adder stages.

Parameters:
- data_size, 32, width of exp, sum and result words; unsigned fixed point with frac_bits fractional bits.
- number_of_data, 10, buffer depth (elements per softmax vector).
- frac_bits, 16, fractional bits of all operands and the result (Q16.16 at defaults).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- exp_i  in  data_size  exp value from exp stage.
- exp_valid_i  in  1  exp_i valid this cycle.
- exp_done_i  in  1  one-cycle pulse: last exp of the vector has been delivered (same cycle as, or after, the last exp_valid_i).
- sum_i  in  data_size  exp sum from adder stage.
- sum_valid_i  in  1  sum_i valid this cycle.
- softmax_o  out  data_size  normalised result.
- softmax_valid_o  out  1  softmax_o valid, one-cycle pulse per element.
- softmax_done_o  out  1  one-cycle pulse, asserted in the same cycle as the last softmax_valid_o.
- busy_o  out  1  high from the first accepted exp until the cycle after softmax_done_o.
- overflow_o  out  1  sticky: an exp arrived while the buffer was full; cleared only by reset.

Behaviour:
- Reset (reset_i high at a clock edge): every output is 0, state returns to COLLECT, and pointers, count, sum_reg, sum_seen and done_seen clear. Reset mid-division aborts the operation with no further outputs.
- State COLLECT:
  - exp_valid_i with count < number_of_data: write buffer[count], then count++.
  - exp_valid_i with count == number_of_data: data dropped, overflow_o set.
  - sum_valid_i: latch sum_reg, set sum_seen.
  - exp_done_i: set done_seen.
  - An exp_valid_i and exp_done_i arriving in the same cycle both take effect.
  - Move to DIVIDE when done_seen and sum_seen are both set. These flags are evaluated including the current cycle's updates.
  - If count == 0 at that point, go straight to FINISH.
- State DIVIDE: load dividend = buffer[rd_ptr] << frac_bits (2*data_size bits) and divisor = sum_reg, then pulse the divider start.
- The divider takes exactly 2*data_size cycles (64 at defaults), one restoring step per cycle.
- State EMIT (1 cycle):
  - softmax_o = quotient[data_size-1:0], saturated to all-ones if any upper quotient bit is set.
  - softmax_valid_o = 1; rd_ptr++.
  - If rd_ptr was count-1: also assert softmax_done_o and go to FINISH; otherwise return to DIVIDE.
- Latency: first softmax_valid_o occurs 2*data_size+2 cycles after the COLLECT→DIVIDE transition. Consecutive outputs are spaced 2*data_size+2 cycles apart.
- Divide-by-zero (sum_reg == 0): the divider is skipped. EMIT outputs all-ones in the cycle after DIVIDE; the done rules are unchanged.
- State FINISH (1 cycle): clear count, pointers and flags; busy_o drops; return to COLLECT.
- Inputs arriving in DIVIDE, EMIT or FINISH (exp_valid_i, sum_valid_i, exp_done_i) are ignored; overflow_o is not set.
- Empty vector (exp_done_i and sum with no exps): softmax_done_o pulses once in FINISH with no softmax_valid_o. This is the only case where done is not coincident with valid.
- Arithmetic is unsigned throughout. The remainder is discarded and the result is truncated (no rounding).

Decomposition:
- Shared package (softmax_pkg): data_size/number_of_data/frac_bits defaults, the state encoding (COLLECT, DIVIDE, EMIT, FINISH), and Q-format constants ONE = 1<<frac_bits and SAT = all-ones.
- Sub-module restoring_divider:
  - Parameterised dividend width (2*data_size) and divisor width (data_size).
  - Ports: start, dividend, divisor, busy, done, quotient.
  - Same clock_i/reset_i.
- Buffer: flat register array inside the top module (no RAM macro).

Test Plan:
1. exps 0x00010000, 0x00010000; sum 0x00020000; exp_done_i with the last exp -> two outputs 0x00008000, second with softmax_done_o; overflow_o=0.
2. exps 0x00010000, 0x00008000, 0x00008000; sum 0x00020000 arriving 5 cycles after exp_done_i -> outputs 0x00008000, 0x00004000, 0x00004000; first valid 66 cycles after the sum cycle.
3. Sum 0 with exps 0x00001000 ×2 -> outputs 0xFFFFFFFF ×2 with no divider run (valid one cycle after DIVIDE); done pulses with the second.
4. 11 exps with number_of_data=10 -> overflow_o=1 stays high; exactly 10 outputs; the 11th value is never emitted.
5. Exp 0x00020000 with sum 0x00010000 (ratio 2.0) -> 0x00020000. Separately, exp 0xFFFF0000 with sum 0x00000001 -> saturates to 0xFFFFFFFF.
6. reset_i asserted 20 cycles into the first division -> all outputs 0 next cycle, no valid. A following clean vector (case 1) produces correct results.
